// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and default constants for the register write arbiter.
package reg_write_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_MAX_HOLD = 4;

endpackage

// File: rtl/reg_write_arbiter_rr_select.sv
// Round-robin selector: searches from last_owner+1 (mod NUM_REQ) and
// returns the first asserted request.
module rr_select
  import reg_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_owner,
  output logic               any,
  output logic [IW-1:0]      winner
);

  logic [IW-1:0] idx;

  always_comb begin
    any    = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = IW'((int'(last_owner) + i) % NUM_REQ);
      if (!any && req[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting write ownership of one shared register,
// with a bounded number of consecutive writes while others are waiting.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  localparam int IW = $clog2(NUM_REQ),
  localparam int HW = $clog2(MAX_HOLD + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] in_words,
  output logic [NUM_REQ-1:0]       grant,
  output logic [IW-1:0]            owner_id,
  output logic [WIDTH-1:0]         out_word,
  output logic                     out_valid,
  output arb_state_e               fsm_state
);

  arb_state_e         state_q, state_d;
  logic [IW-1:0]      owner_q, owner_d, last_q, last_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic [NUM_REQ-1:0] grant_d;
  logic               write_en;

  logic [NUM_REQ-1:0] sel_req;
  logic [IW-1:0]      sel_last, winner;
  logic               any;

  // While owning, the owner is masked out and the search starts after it,
  // so the released owner ends up with the lowest priority.
  assign sel_req  = (state_q == OWN) ? (req & ~grant) : req;
  assign sel_last = (state_q == OWN) ? owner_q : last_q;

  rr_select #(.NUM_REQ(NUM_REQ)) u_rr_select (
    .req        (sel_req),
    .last_owner (sel_last),
    .any        (any),
    .winner     (winner)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    hold_d   = hold_q;
    write_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (any) begin
          state_d = OWN;
          owner_d = winner;
          hold_d  = '0;
        end
      end
      OWN: begin
        write_en = req[owner_q];
        if (write_en && hold_q != HW'(MAX_HOLD)) hold_d = hold_q + 1'b1;
        // Hold limit only forces a handover when someone else is waiting.
        if (!write_en || (hold_d == HW'(MAX_HOLD) && any)) begin
          last_d = owner_q;
          hold_d = '0;
          if (any) begin
            owner_d = winner;
          end else begin
            state_d = IDLE;
            owner_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d = '0;
    if (state_d == OWN) grant_d[owner_d] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      last_q    <= IW'(NUM_REQ - 1);
      hold_q    <= '0;
      grant     <= '0;
      out_word  <= '0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      grant     <= grant_d;
      out_valid <= write_en;
      if (write_en) out_word <= in_words[int'(owner_q)*WIDTH +: WIDTH];
    end
  end

  assign owner_id  = owner_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed and random stimulus for reg_write_arbiter against a behavioural
// model; written words flow through an expected queue.
module tb_reg_write_arbiter;
  import reg_write_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MH = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] in_words = '0;
  logic [N-1:0]   grant;
  logic [1:0]     owner_id;
  logic [W-1:0]   out_word;
  logic           out_valid;
  arb_state_e     fsm_state;

  reg_write_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .in_words  (in_words),
    .grant     (grant),
    .owner_id  (owner_id),
    .out_word  (out_word),
    .out_valid (out_valid),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  // behavioural model state
  bit m_own;
  int m_owner, m_hold, m_last;
  bit m_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [N-1:0] r);
    for (int i = 1; i <= N; i++)
      if (r[(last + i) % N]) return (last + i) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_own = 0; m_owner = 0; m_hold = 0; m_last = N - 1; m_valid = 0;
    exp_q.delete();
  endtask

  task automatic model_edge();
    logic [N-1:0] others;
    bit wr;
    int w;
    m_valid = 0;
    if (!m_own) begin
      w = rr_pick(m_last, req);
      if (w >= 0) begin m_own = 1; m_owner = w; m_hold = 0; end
    end else begin
      others = req;
      others[m_owner] = 1'b0;
      wr = req[m_owner];
      if (wr) begin
        exp_q.push_back(in_words[m_owner*W +: W]);
        m_valid = 1;
        if (m_hold < MH) m_hold++;
      end
      if (!wr || (m_hold == MH && others != 0)) begin
        m_last = m_owner;
        m_hold = 0;
        if (others != 0) m_owner = rr_pick(m_last, others);
        else begin m_own = 0; m_owner = 0; end
      end
    end
  endtask

  task automatic check_cycle();
    logic [N-1:0] eg;
    logic [W-1:0] ew;
    eg = '0;
    if (m_own) eg[m_owner] = 1'b1;
    chk("grant", grant, eg);
    chk("owner_id", owner_id, m_own ? m_owner : 0);
    chk("state", fsm_state, m_own);
    chk("out_valid", out_valid, m_valid);
    chk("grant_onehot0", $onehot0(grant), 1);
    if (out_valid === 1'b1) begin
      chk("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        ew = exp_q.pop_front();
        chk("out_word", out_word, ew);
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk); #1;
    check_cycle();
  endtask

  // called at posedge+1; reset pulse stays inside one clock period
  task automatic do_reset();
    req = '0;
    reset = 1'b1;
    #2;
    chk("rst_grant", grant, 0);
    chk("rst_owner", owner_id, 0);
    chk("rst_word", out_word, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_state", fsm_state, IDLE);
    model_reset();
    #2 reset = 1'b0;
  endtask

  initial begin
    int pulses;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // single requester: grant after one edge, data after two
    req = 4'b0001; in_words[0 +: W] = 8'h01;
    tick(); chk("t1_grant", grant, 4'b0001);
    tick(); chk("t1_word", out_word, 8'h01); chk("t1_valid", out_valid, 1);
    req = '0; tick(); tick();

    // two requesters: four writes of AA then handover to 1
    @(posedge clk); #1; do_reset();
    req = 4'b0011; in_words[0 +: W] = 8'hAA; in_words[W +: W] = 8'h55;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick(); chk("t2_word_aa", out_word, 8'hAA);
    end
    chk("t2_handover", grant, 4'b0010);
    tick(); chk("t2_word_55", out_word, 8'h55);
    req = '0; tick(); tick();

    // lone requester keeps ownership past the hold limit
    @(posedge clk); #1; do_reset();
    req = 4'b0100; in_words[2*W +: W] = 8'hFF;
    pulses = 0;
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) pulses++;
      chk("t3_grant", grant, 4'b0100);
    end
    chk("t3_pulses", pulses, 10);
    chk("t3_word", out_word, 8'hFF);
    req = '0; tick();

    // all requesting: rotation with four writes each
    @(posedge clk); #1; do_reset();
    req = 4'b1111;
    in_words = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int t = 1; t <= 17; t++) begin
      tick();
      if ((t - 1) % 4 == 0) chk("t4_rotation", grant, 4'b0001 << (((t - 1) / 4) % 4));
    end
    req = '0; tick(); tick();

    // owner drops request: no write, direct handover
    @(posedge clk); #1; do_reset();
    req = 4'b1010; in_words[W +: W] = 8'h66; in_words[3*W +: W] = 8'h99;
    tick(); chk("t5_grant1", grant, 4'b0010);
    tick(); tick();
    req = 4'b1000;
    tick();
    chk("t5_no_write", out_valid, 0);
    chk("t5_grant3", grant, 4'b1000);
    chk("t5_no_idle", fsm_state, OWN);
    tick(); chk("t5_word", out_word, 8'h99);
    req = '0; tick();

    // asynchronous reset mid-ownership
    @(posedge clk); #1; do_reset();
    req = 4'b0001; in_words[0 +: W] = 8'h5A;
    tick(); tick();
    #3 reset = 1'b1;
    #1;
    chk("t6_grant", grant, 0);
    chk("t6_word", out_word, 0);
    chk("t6_valid", out_valid, 0);
    model_reset();
    req = 4'b0010;
    #1 reset = 1'b0;
    tick(); chk("t6_regrant", grant, 4'b0010);
    req = '0; tick(); tick();

    // random traffic
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 15));
      in_words = {W'($urandom), W'($urandom), W'($urandom), W'($urandom)};
      tick();
    end
    req = '0; tick(); tick();
    chk("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
